fifo_rd_packer: RTL
===================

Name: fifo_rd_packer

Overview:
Read-side consumer of the async FIFO, in the FIFO read clock domain. It pops DW-bit entries from the FIFO read port and packs N consecutive entries into one N*DW-bit word. Words leave on a valid/ready stream through a single output register. A flush request emits a partial word with a byte-keep mask, so trailing data is never stranded.

Parameters:
DW, 8, width of one FIFO entry (rdata width)
N, 4, entries packed per output word (N >= 2)

Ports:
rclk  input  1  read-domain clock, all logic on rising edge
rrst_n  input  1  asynchronous active-low reset
rempty  input  1  FIFO empty flag, synchronous to rclk
rdata  input  DW  FIFO head entry; valid whenever rempty=0 (first-word-fall-through)
rinc  output  1  FIFO pop strobe; head consumed at rclk edge when rinc=1
flush  input  1  single-cycle request to emit the current partial word
out_valid  output  1  output word valid
out_ready  input  1  downstream accepts word when out_valid&&out_ready at rclk edge
out_data  output  N*DW  packed word; first-popped entry in bits [DW-1:0]
out_keep  output  N  lane-valid mask; bit k=1 means lane k holds data
busy  output  1  cnt!=0 or out_valid or flush pending

Behaviour:
- Reset (rrst_n=0, async): acc=0, cnt=0, flush_pend=0, out_valid=0, out_data=0, out_keep=0. rinc=0 while in reset. Reset mid-word discards the accumulated entries. Deassertion takes effect at the next rclk edge.
- State: accumulator acc[N*DW]; lane counter cnt, 0..N, width clog2(N+1); flush_pend flag; output register.
- load_ok = !out_valid || out_ready (combinational).
- Full load: cnt==N && load_ok.
  - out_data<=acc, out_keep<=all ones, out_valid<=1.
  - cnt<=0, or cnt<=1 if a pop occurs in the same cycle.
  - flush_pend<=0.
- Partial load: cnt in 1..N-1 && (flush || flush_pend) && load_ok.
  - out_data<=acc with unused lanes zero.
  - out_keep<=(1<<cnt)-1, out_valid<=1.
  - cnt<=0, flush_pend<=0.
- Pop rule: rinc = !rempty && !partial_load && (cnt<N || full_load).
  - Combinational path from out_ready to rinc is intended.
  - Sustained throughput is 1 entry per clock when out_ready=1.
- On pop: the entry is written to lane cnt, or lane 0 when a full load happens in the same cycle. cnt increments.
- Flush handling:
  - flush with cnt==0 and no pop in that cycle is dropped.
  - flush with cnt==N is satisfied by the full load; flush_pend clears.
  - flush when a partial load cannot happen (output blocked, or a pop in that cycle) sets flush_pend.
  - While flush_pend=1, popping continues. If cnt reaches N, the full load clears flush_pend.
- Output hold: while out_valid && !out_ready, out_data and out_keep stay stable. out_valid clears on accept only when no new load occurs.
- cnt never exceeds N. Entries are never popped when acc has no free lane and no full load occurs.
- No combinational path from rdata to outputs other than through registers.

Test Plan:
- Reset, rempty=0, FIFO holds 0x00..0x07, out_ready=1 -> words 0x03020100 then 0x07060504, keep=0xF, rinc high 8 consecutive cycles, no bubble.
- Hold out_ready=0 with 12 entries available -> exactly 8 pops. First word held stable, cnt=4, rinc=0. Then out_ready=1 -> remaining words in order, no loss.
- Pop 0xA1,0xA2,0xA3, rempty=1, pulse flush -> next cycle out_data=0x00A3A2A1, keep=0x7, busy drops after accept.
- Flush while out_valid=1 and out_ready=0 with cnt=2 -> flush_pend=1. Once out_ready=1, partial word keep=0x3 follows the held word.
- Flush with cnt=0 and rempty=1 -> no out_valid, flush_pend stays 0.
- Assert rrst_n=0 with cnt=3 and out_valid=1 -> all outputs 0 immediately. After release, first word contains only post-reset entries.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer of the async FIFO (rclk domain).
// Pops DW-bit entries and packs N of them into one N*DW-bit output word.
// A flush request pushes out a partial word with a lane-keep mask.
//
// Handshakes:
//   FIFO side: rdata is valid whenever rempty=0 (first-word-fall-through);
//   the head is consumed at the rclk edge where rinc=1.
//   Output side: the word transfers at the rclk edge where
//   out_valid && out_ready. While out_valid && !out_ready, out_data and
//   out_keep hold. out_valid never drops without a transfer.
module fifo_rd_packer #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic            rempty,
  input  logic [DW-1:0]   rdata,
  output logic            rinc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]    out_keep,
  output logic            busy
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N);

  logic [N*DW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_flush_pend;
  logic            r_out_valid;
  logic [N*DW-1:0] r_out_data;
  logic [N-1:0]    r_out_keep;

  logic            w_load_ok;
  logic            w_full_load;
  logic            w_partial_load;
  logic            w_pop;
  logic [CW-1:0]   w_lane;
  logic [N-1:0]    w_part_keep;
  logic [N*DW-1:0] w_acc_next;
  logic [CW-1:0]   w_cnt_next;
  logic            w_flush_pend_next;

  // The output register can take a new word when empty or being drained now.
  assign w_load_ok      = !r_out_valid || out_ready;
  assign w_full_load    = (r_cnt == CNT_FULL) && w_load_ok;
  assign w_partial_load = (r_cnt != '0) && (r_cnt != CNT_FULL) &&
                          (flush || r_flush_pend) && w_load_ok;

  // Pop only when a lane is free now or is freed by a full load this cycle.
  // A partial load suppresses the pop so the flushed word is exactly what was
  // accumulated. out_ready reaches rinc combinationally to keep 1 entry/clock.
  assign w_pop  = rrst_n && !rempty && !w_partial_load &&
                  ((r_cnt < CNT_FULL) || w_full_load);
  assign w_lane = w_full_load ? '0 : r_cnt;

  // Keep mask for a partial word: the lowest cnt lanes hold data.
  always_comb begin
    w_part_keep = '0;
    for (int k = 0; k < N; k++) begin
      if (k < int'(r_cnt)) w_part_keep[k] = 1'b1;
    end
  end

  // Next accumulator: cleared on any load so unused lanes read as zero, then
  // the popped entry lands in its lane.
  always_comb begin
    w_acc_next = r_acc;
    if (w_full_load || w_partial_load) w_acc_next = '0;
    if (w_pop) begin
      for (int k = 0; k < N; k++) begin
        if (int'(w_lane) == k) w_acc_next[k*DW +: DW] = rdata;
      end
    end
  end

  // Next lane count and flush-pending flag.
  always_comb begin
    w_cnt_next        = r_cnt;
    w_flush_pend_next = r_flush_pend;
    if (w_full_load || w_partial_load) begin
      w_cnt_next        = '0;
      w_flush_pend_next = 1'b0;
    end else if (flush && ((r_cnt != '0) || w_pop)) begin
      // Flush could not be served this cycle; remember it.
      w_flush_pend_next = 1'b1;
    end
    if (w_pop) w_cnt_next = w_cnt_next + CW'(1);
  end

  // Accumulator, lane counter and flush-pending state.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_acc        <= w_acc_next;
      r_cnt        <= w_cnt_next;
      r_flush_pend <= w_flush_pend_next;
    end
  end

  // Output register: load full or partial word, else drop valid on accept.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
    end else if (w_full_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_acc;
      r_out_keep  <= '1;
    end else if (w_partial_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_acc;
      r_out_keep  <= w_part_keep;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign rinc      = w_pop;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign busy      = (r_cnt != '0) || r_out_valid || r_flush_pend;

endmodule
